// File: rtl/sound_scheduler.sv
// Sound sequencer: turns game events (BAD/GOOD collision, direction change) into timed tone notes.
// Optional SOUND_SCHED_PREEMPT_EN lets a BAD event abort a running GOOD or DIR sequence.
module sound_scheduler #(
   parameter int unsigned NOTE_TICKS = 1000,
   parameter logic [7:0]  P_GOOD1    = 8'd120,
   parameter logic [7:0]  P_GOOD2    = 8'd80,
   parameter logic [7:0]  P_BAD1     = 8'd200,
   parameter logic [7:0]  P_BAD2     = 8'd250,
   parameter logic [7:0]  P_DIR      = 8'd160
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       button_i,
   input  logic       goodColl_i,
   input  logic       badColl_i,
   input  logic [3:0] direction_i,
   output logic       play_o,
   output logic [7:0] period_o,
   output logic       mute_o,
   output logic       busy_o
);

   localparam int unsigned CW = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(NOTE_TICKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_NOTE_A, S_NOTE_B} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_BAD, SRC_GOOD, SRC_DIR} src_t;

   state_t        state, state_n;
   src_t          src, src_n, pick;
   logic [CW-1:0] cnt;
   logic          pend_bad, pend_good, pend_dir;
   logic          prev_btn, prev_good, prev_bad;
   logic [3:0]    prev_dir;
   logic          btn_ev, good_ev, bad_ev, dir_ev, mute_enter, mute_n;
   logic          note_end, seq_done, load;
   logic          clr_bad, clr_good, clr_dir;
   logic          play_n, busy_n;
   logic [7:0]    period_n;

   // Events are dropped while muted; the button edge itself is never gated
   assign btn_ev     = button_i & ~prev_btn;
   assign good_ev    = goodColl_i & ~prev_good & ~mute_o;
   assign bad_ev     = badColl_i & ~prev_bad & ~mute_o;
   assign dir_ev     = (direction_i != '0) && (direction_i != prev_dir) && !mute_o;
   assign mute_enter = btn_ev & ~mute_o;
   assign mute_n     = mute_o ^ btn_ev;
   assign note_end   = (state != S_IDLE) && (cnt == '0);

   always_comb begin
      if (pend_bad)       pick = SRC_BAD;
      else if (pend_good) pick = SRC_GOOD;
      else if (pend_dir)  pick = SRC_DIR;
      else                pick = SRC_NONE;
   end

   always_comb begin
      state_n  = state;
      src_n    = src;
      load     = 1'b0;
      seq_done = 1'b0;
      clr_bad  = 1'b0;
      clr_good = 1'b0;
      clr_dir  = 1'b0;
      period_n = '0;
      case (state)
         S_IDLE:   seq_done = 1'b1;
         S_NOTE_A: if (note_end) begin
            if (src == SRC_DIR) seq_done = 1'b1;
            else begin
               state_n = S_NOTE_B;
               load    = 1'b1;
            end
         end
         S_NOTE_B: if (note_end) seq_done = 1'b1;
         default:  seq_done = 1'b1;
      endcase
      // A finished sequence chains straight into the next pending source
      if (seq_done) begin
         if (pick != SRC_NONE) begin
            state_n = S_NOTE_A;
            src_n   = pick;
            load    = 1'b1;
         end else begin
            state_n = S_IDLE;
            src_n   = SRC_NONE;
         end
         clr_bad  = (pick == SRC_BAD);
         clr_good = (pick == SRC_GOOD);
         clr_dir  = (pick == SRC_DIR);
      end
`ifdef SOUND_SCHED_PREEMPT_EN
      if ((state != S_IDLE) && pend_bad && (src != SRC_BAD)) begin
         state_n  = S_NOTE_A;
         src_n    = SRC_BAD;
         load     = 1'b1;
         clr_bad  = 1'b1;
         clr_good = 1'b0;
         clr_dir  = 1'b0;
      end
`endif
      if (mute_enter) begin
         state_n  = S_IDLE;
         src_n    = SRC_NONE;
         load     = 1'b0;
         clr_bad  = 1'b0;
         clr_good = 1'b0;
         clr_dir  = 1'b0;
      end
      case (state_n)
         S_NOTE_A: case (src_n)
            SRC_BAD:  period_n = P_BAD1;
            SRC_GOOD: period_n = P_GOOD1;
            SRC_DIR:  period_n = P_DIR;
            default:  period_n = '0;
         endcase
         S_NOTE_B: case (src_n)
            SRC_BAD:  period_n = P_BAD2;
            SRC_GOOD: period_n = P_GOOD2;
            default:  period_n = '0;
         endcase
         default:  period_n = '0;
      endcase
   end

   assign busy_n = (state_n != S_IDLE);
   assign play_n = busy_n & ~mute_n;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state     <= S_IDLE;
         src       <= SRC_NONE;
         cnt       <= '0;
         pend_bad  <= 1'b0;
         pend_good <= 1'b0;
         pend_dir  <= 1'b0;
         prev_btn  <= 1'b0;
         prev_good <= 1'b0;
         prev_bad  <= 1'b0;
         prev_dir  <= '0;
         mute_o    <= 1'b0;
         play_o    <= 1'b0;
         period_o  <= '0;
         busy_o    <= 1'b0;
      end else begin
         prev_btn  <= button_i;
         prev_good <= goodColl_i;
         prev_bad  <= badColl_i;
         prev_dir  <= direction_i;
         mute_o    <= mute_n;
         state     <= state_n;
         src       <= src_n;
         if (mute_enter) begin
            pend_bad  <= 1'b0;
            pend_good <= 1'b0;
            pend_dir  <= 1'b0;
         end else begin
            pend_bad  <= (pend_bad & ~clr_bad) | bad_ev;
            pend_good <= (pend_good & ~clr_good) | good_ev;
            pend_dir  <= (pend_dir & ~clr_dir) | dir_ev;
         end
         if (load)                  cnt <= CNT_LOAD;
         else if (state_n == S_IDLE) cnt <= '0;
         else if (cnt != '0)        cnt <= cnt - CW'(1);
         play_o   <= play_n;
         period_o <= period_n;
         busy_o   <= busy_n;
      end
   end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 SHALL have parameter NOTE_TICKS, default 1000, clock cycles per note (minimum 2).
REQ-002 SHALL have parameter P_GOOD1, default 8'd120, P_GOOD2 default 8'd80, P_BAD1 default 8'd200, P_BAD2 default 8'd250, P_DIR default 8'd160, tone half-period codes.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port button_i  input  1  mute toggle request, synchronous level.
REQ-006 SHALL have port goodColl_i  input  1  good-collision event, level, sampled each edge.
REQ-007 SHALL have port badColl_i  input  1  bad-collision event, level, sampled each edge.
REQ-008 SHALL have port direction_i  input  4  current snake direction, one-hot or zero.
REQ-009 SHALL have port play_o  output  1  sound generator enable.
REQ-010 SHALL have port period_o  output  8  tone half-period code to sound generator.
REQ-011 SHALL have port mute_o  output  1  mute state.
REQ-012 SHALL have port busy_o  output  1  sequence in progress (state != IDLE).

Function
REQ-013 SHALL detect rising edges of button_i, goodColl_i, badColl_i via registered previous values; a held level counts as one event.
REQ-014 SHALL treat a direction event as direction_i != 0 and direction_i != registered previous direction.
REQ-015 SHALL hold one pending flag per source (BAD, GOOD, DIR), set at the edge the event is detected; repeat events while pending set are merged.
REQ-016 SHALL serve pending sources in fixed priority BAD > GOOD > DIR; served flag cleared at the edge the sequence starts.
REQ-017 SHALL run FSM states IDLE, NOTE_A, NOTE_B: IDLE -> NOTE_A when any flag pending; NOTE_A -> NOTE_B (BAD, GOOD) or IDLE (DIR) at note end; NOTE_B -> IDLE at note end.
REQ-018 SHALL use a note counter loaded with NOTE_TICKS-1 on note entry and decremented each cycle; note ends at the edge where counter is 0, so each note lasts exactly NOTE_TICKS cycles.
REQ-019 SHALL drive period_o: BAD = P_BAD1 then P_BAD2; GOOD = P_GOOD1 then P_GOOD2; DIR = P_DIR; period_o = 0 in IDLE.
REQ-020 SHALL register all outputs; play_o = 1 exactly in NOTE_A/NOTE_B while unmuted.
REQ-021 SHALL have latency: event input rising before edge N -> pending at edge N -> play_o high after edge N+1 (FSM idle).
REQ-022 SHALL return IDLE -> NOTE_A directly at note end of a finished sequence if another flag is pending (no idle cycle).
REQ-023 SHALL toggle mute_o on each button_i rising edge; entering mute forces IDLE, clears all pending flags, play_o = 0 at next edge.
REQ-024 SHALL ignore (not latch) all events while mute_o = 1; previous-value registers still update.
REQ-025 SHALL latch all simultaneous events in the same cycle and play them back-to-back in priority order.

Reset
REQ-026 SHALL on nRst low immediately force: state IDLE, play_o 0, period_o 0, mute_o 0, busy_o 0, pending flags 0, counter 0, previous-value registers 0.
REQ-027 SHALL, on reset mid-sequence, abandon the sequence with no resumption after release.
REQ-028 SHALL not detect an event from input levels already high at reset release until they fall and rise again (previous regs reset 0 excepted: a level high at release counts as one event).

Configuration
REQ-029 SHALL, with SOUND_SCHED_PREEMPT_EN defined, let a BAD event abort a running GOOD or DIR sequence: next edge enters NOTE_A with P_BAD1, counter reloaded, BAD flag cleared; aborted sequence dropped.
REQ-030 SHALL, without SOUND_SCHED_PREEMPT_EN, queue BAD until the running sequence ends (REQ-022).

Verification (NOTE_TICKS=4)
REQ-031 SHALL cover reset: nRst low mid-NOTE_A -> play_o 0, period_o 0, busy_o 0 immediately; no sound after release.
REQ-032 SHALL cover GOOD: one-cycle goodColl_i pulse -> play_o 1 two edges later, period_o 120 for 4 cycles, 80 for 4 cycles, then play_o 0.
REQ-033 SHALL cover simultaneous: goodColl_i, badColl_i, direction_i 0001 same cycle -> periods 200,250,120,80,160 at 4 cycles each, no gaps.
REQ-034 SHALL cover direction: direction_i 0001 held 20 cycles -> one 160 note only; change to 0010 -> second note; change to 0000 -> none.
REQ-035 SHALL cover mute: button_i pulse -> mute_o 1; goodColl_i pulse -> play_o stays 0; second pulse -> mute_o 0, next event plays.
REQ-036 SHALL cover preempt: badColl_i in cycle 2 of GOOD note -> with macro period_o 200 one edge after detection; without macro after GOOD ends.
